// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encoding, counter widths and helpers for the PLL lock sequencer.
package pll_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_PRST   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;
  localparam state_t ST_RUN    = 2'd3;

  localparam int RETRY_W = 8;
  localparam int LOSS_W  = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// Multi-stage single-bit synchronizer with synchronous clear, for asynchronous status inputs.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for stable lock, then releases sys_rst.
// Optional lock-loss counter output is enabled with PLL_LOCK_LOSS_CNT_EN.
//
// state  | meaning
// PRST   | pll_rst held high for RST_CYCLES
// WAIT   | waiting for synchronized lock, LOCK_TIMEOUT then retry
// SETTLE | lock must stay high for STABLE_CYCLES
// RUN    | core released, ready high
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]  lock_loss_cnt
`endif
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STABLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lk;
  logic             retry_inc;

  // The lock flag is meaningless while the PLL is held in reset, so the synchronizer is
  // cleared then too; lock is only seen SYNC_STAGES+1 cycles after pll_rst falls.
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk (clk),
    .rst (rst | pll_rst),
    .d   (pll_locked),
    .q   (lk)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
    retry_inc = 1'b0;
    if (relock_req) begin
      state_nxt = ST_PRST;
      cnt_nxt   = RST_LOAD;
    end else begin
      case (state)
        ST_PRST: begin
          if (cnt == '0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = TMO_LOAD;
          end
        end
        ST_WAIT: begin
          if (lk) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = STB_LOAD;
          end else if (cnt == '0) begin
            state_nxt = ST_PRST;
            cnt_nxt   = RST_LOAD;
            retry_inc = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!lk) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = TMO_LOAD;
          end else if (cnt == '0) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!lk) begin
            state_nxt = ST_PRST;
            cnt_nxt   = RST_LOAD;
          end
        end
        default: begin
          state_nxt = ST_PRST;
          cnt_nxt   = RST_LOAD;
        end
      endcase
    end
  end

  // Reset is itself the PRST entry, so the hold count is loaded here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PRST;
      cnt       <= RST_LOAD;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pll_rst <= (state_nxt == ST_PRST);
      sys_rst <= (state_nxt != ST_RUN);
      ready   <= (state_nxt == ST_RUN);
      if (retry_inc && (retry_cnt != {RETRY_W{1'b1}})) retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic lock_lost;
  assign lock_lost = (state == ST_RUN) && !relock_req && !lk;

  always_ff @(posedge clk) begin
    if (rst)                                                lock_loss_cnt <= '0;
    else if (lock_lost && (lock_loss_cnt != {LOSS_W{1'b1}})) lock_loss_cnt <= lock_loss_cnt + LOSS_W'(1);
  end
`endif

endmodule
